// File: rtl/bus_pkg.sv
// Shared types for the simple-bus slave endpoints: response codes, slave FSM
// states, channel tags and the address width used by every slave.
package bus_pkg;

  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum {ST_IDLE, ST_WAIT, ST_RESP} slv_state_e;

  // Which channel a latched transaction came from
  typedef enum logic {
    CH_WR = 1'b0,
    CH_RD = 1'b1
  } chan_e;

  // 16-bit status counter increment that sticks at all-ones
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/bus_slave_arb.sv
// Two-way round-robin grant between the write and read channels.
// The last-served flop only moves on a contested grant, so the loser of one
// collision is the winner of the next; uncontested grants leave it alone.
module bus_slave_arb
  import bus_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_w,
  input  logic req_r,
  input  logic accept,
  output logic gnt_w,
  output logic gnt_r
);

  chan_e last_ch_reg;

  // Grant: a lone requester always wins; on a collision the channel not served last wins
  always_comb begin
    gnt_w = req_w && (!req_r || (last_ch_reg == CH_RD));
    gnt_r = req_r && (!req_w || (last_ch_reg == CH_WR));
  end

  // Last-served flop; reset pretends read was served last so write wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ch_reg <= CH_RD;
    end else if (accept && req_w && req_r) begin
      last_ch_reg <= gnt_w ? CH_WR : CH_RD;
    end
  end

endmodule

// File: rtl/bus_slave_mem.sv
// Memory-backed slave endpoint on the simple bus. Accepts one write or read
// at a time, waits LATENCY cycles, then returns a registered one-cycle ready
// pulse with a response code. Keeps saturating status counters for debug.
// DEPTH must be at least 2 and at most 256.
module bus_slave_mem
  import bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h00,
  parameter int                DEPTH     = 64,
  parameter int                DATA_W    = 8,
  parameter int                ID_W      = 4,
  parameter int                LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_valid,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ID_W-1:0]   w_id,
  output logic              w_ready,
  output logic [1:0]        w_resp,
  input  logic              r_valid,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [ID_W-1:0]   r_id,
  output logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic [15:0]       wr_cnt,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       err_cnt
);

  localparam int          IDX_W  = $clog2(DEPTH);
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  slv_state_e state_reg, state_next;
  logic [3:0] lat_cnt_reg, lat_cnt_next;

  chan_e             ch_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic [ID_W-1:0]   id_reg;

  logic              w_ready_reg, r_ready_reg;
  logic [1:0]        w_resp_reg, r_resp_reg;
  logic [DATA_W-1:0] r_data_reg;
  logic [15:0]       wr_cnt_reg, rd_cnt_reg, err_cnt_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_w, req_r, gnt_w, gnt_r;
  logic              accept, resp_fire;
  logic [ADDR_W-1:0] off;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              unused_id;

  // The id is captured with the request but this endpoint has no id return path
  assign unused_id = ^id_reg;

  // A channel whose ready pulse is on the wire still shows its old valid this
  // cycle; masking it keeps that old request from being accepted a second time.
  assign req_w = w_valid && !w_ready_reg;
  assign req_r = r_valid && !r_ready_reg;

  bus_slave_arb u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_w  (req_w),
    .req_r  (req_r),
    .accept (accept),
    .gnt_w  (gnt_w),
    .gnt_r  (gnt_r)
  );

  // Address decode of the latched transaction, compared in 9 bits so nothing wraps
  always_comb begin
    off      = addr_reg - BASE_ADDR;
    in_range = ({1'b0, addr_reg} >= {1'b0, BASE_ADDR}) && ({1'b0, off} < 9'(DEPTH));
    idx      = off[IDX_W-1:0];
  end

  // Next-state logic: IDLE accepts, WAIT counts latency down, RESP fires once
  always_comb begin
    state_next   = state_reg;
    lat_cnt_next = lat_cnt_reg;
    accept       = 1'b0;
    resp_fire    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (gnt_w || gnt_r) begin
          accept       = 1'b1;
          lat_cnt_next = LAT_M1;
          state_next   = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_reg == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          lat_cnt_next = lat_cnt_reg - 4'd1;
        end
      end
      ST_RESP: begin
        resp_fire  = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state, latency counter and request capture at acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      lat_cnt_reg <= 4'd0;
      ch_reg      <= CH_WR;
      addr_reg    <= '0;
      data_reg    <= '0;
      id_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      lat_cnt_reg <= lat_cnt_next;
      if (accept) begin
        ch_reg   <= gnt_w ? CH_WR : CH_RD;
        addr_reg <= gnt_w ? w_addr : r_addr;
        data_reg <= w_data;
        id_reg   <= gnt_w ? w_id : r_id;
      end
    end
  end

  // Storage: cleared by reset, written only on the RESP cycle of an in-range write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (resp_fire && (ch_reg == CH_WR) && in_range) begin
      mem[idx] <= data_reg;
    end
  end

  // Registered response outputs: one-cycle ready pulse, payload zero otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ready_reg <= 1'b0;
      r_ready_reg <= 1'b0;
      w_resp_reg  <= 2'b00;
      r_resp_reg  <= 2'b00;
      r_data_reg  <= '0;
    end else begin
      w_ready_reg <= 1'b0;
      r_ready_reg <= 1'b0;
      w_resp_reg  <= 2'b00;
      r_resp_reg  <= 2'b00;
      r_data_reg  <= '0;
      if (resp_fire) begin
        if (ch_reg == CH_WR) begin
          w_ready_reg <= 1'b1;
          w_resp_reg  <= in_range ? OKAY : SLVERR;
        end else begin
          r_ready_reg <= 1'b1;
          r_resp_reg  <= in_range ? OKAY : SLVERR;
          r_data_reg  <= in_range ? mem[idx] : '0;
        end
      end
    end
  end

  // Saturating status counters, bumped on the RESP cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_reg  <= 16'd0;
      rd_cnt_reg  <= 16'd0;
      err_cnt_reg <= 16'd0;
    end else if (resp_fire) begin
      if (!in_range) begin
        err_cnt_reg <= sat_inc(err_cnt_reg);
      end else if (ch_reg == CH_WR) begin
        wr_cnt_reg <= sat_inc(wr_cnt_reg);
      end else begin
        rd_cnt_reg <= sat_inc(rd_cnt_reg);
      end
    end
  end

  assign w_ready = w_ready_reg;
  assign w_resp  = w_resp_reg;
  assign r_ready = r_ready_reg;
  assign r_resp  = r_resp_reg;
  assign r_data  = r_data_reg;
  assign wr_cnt  = wr_cnt_reg;
  assign rd_cnt  = rd_cnt_reg;
  assign err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: instance a (BASE 8'h40, LATENCY 2) and
// instance b (BASE 8'h00, LATENCY 0) share one clock.
module tb_bus_slave_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        a_rst, a_w_valid, a_r_valid, a_w_ready, a_r_ready;
  logic [7:0]  a_w_addr, a_w_data, a_r_addr, a_r_data;
  logic [3:0]  a_w_id, a_r_id;
  logic [1:0]  a_w_resp, a_r_resp;
  logic [15:0] a_wr_cnt, a_rd_cnt, a_err_cnt;

  logic        b_rst, b_w_valid, b_r_valid, b_w_ready, b_r_ready;
  logic [7:0]  b_w_addr, b_w_data, b_r_addr, b_r_data;
  logic [3:0]  b_w_id, b_r_id;
  logic [1:0]  b_w_resp, b_r_resp;
  logic [15:0] b_wr_cnt, b_rd_cnt, b_err_cnt;

  bus_slave_mem #(.BASE_ADDR(8'h40), .DEPTH(64), .DATA_W(8), .ID_W(4), .LATENCY(2)) dut_a (
    .clk(clk), .rst(a_rst),
    .w_valid(a_w_valid), .w_addr(a_w_addr), .w_data(a_w_data), .w_id(a_w_id),
    .w_ready(a_w_ready), .w_resp(a_w_resp),
    .r_valid(a_r_valid), .r_addr(a_r_addr), .r_id(a_r_id),
    .r_ready(a_r_ready), .r_data(a_r_data), .r_resp(a_r_resp),
    .wr_cnt(a_wr_cnt), .rd_cnt(a_rd_cnt), .err_cnt(a_err_cnt)
  );

  bus_slave_mem #(.BASE_ADDR(8'h00), .DEPTH(64), .DATA_W(8), .ID_W(4), .LATENCY(0)) dut_b (
    .clk(clk), .rst(b_rst),
    .w_valid(b_w_valid), .w_addr(b_w_addr), .w_data(b_w_data), .w_id(b_w_id),
    .w_ready(b_w_ready), .w_resp(b_w_resp),
    .r_valid(b_r_valid), .r_addr(b_r_addr), .r_id(b_r_id),
    .r_ready(b_r_ready), .r_data(b_r_data), .r_resp(b_r_resp),
    .wr_cnt(b_wr_cnt), .rd_cnt(b_rd_cnt), .err_cnt(b_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance a (sel=0) or b (sel=1), checking
  // latency in negedges after the drive (LATENCY+2), response and read data.
  task automatic xfer(input bit sel, input bit wr, input logic [7:0] addr, input logic [7:0] data,
                      input logic [1:0] exp_resp, input logic [7:0] exp_rd, input string tag);
    int         cyc;
    logic       rdy;
    logic [1:0] resp;
    logic [7:0] rd;
    @(negedge clk);
    if (!sel) begin
      if (wr) begin a_w_valid = 1'b1; a_w_addr = addr; a_w_data = data; end
      else    begin a_r_valid = 1'b1; a_r_addr = addr; end
    end else begin
      if (wr) begin b_w_valid = 1'b1; b_w_addr = addr; b_w_data = data; end
      else    begin b_r_valid = 1'b1; b_r_addr = addr; end
    end
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 20) begin
      @(negedge clk);
      cyc++;
      rdy = sel ? (wr ? b_w_ready : b_r_ready) : (wr ? a_w_ready : a_r_ready);
    end
    resp = sel ? (wr ? b_w_resp : b_r_resp) : (wr ? a_w_resp : a_r_resp);
    rd   = sel ? b_r_data : a_r_data;
    check({tag, "_lat"}, cyc, sel ? 2 : 4);
    check({tag, "_resp"}, resp, exp_resp);
    if (!wr) check({tag, "_rdata"}, rd, exp_rd);
    if (!sel) begin a_w_valid = 1'b0; a_r_valid = 1'b0; end
    else      begin b_w_valid = 1'b0; b_r_valid = 1'b0; end
    @(negedge clk);
    rdy  = sel ? (wr ? b_w_ready : b_r_ready) : (wr ? a_w_ready : a_r_ready);
    resp = sel ? (wr ? b_w_resp : b_r_resp) : (wr ? a_w_resp : a_r_resp);
    check({tag, "_pulse1"}, {rdy, resp}, 3'b000);
    $display("xfer %s: dut=%0d %s addr=%02h data=%02h resp=%0b rdata=%02h cycles=%0d",
             tag, sel, wr ? "W" : "R", addr, data, resp, rd, cyc);
  endtask

  // Wait (bounded) for the next ready pulse on instance a
  task automatic a_wait(output logic w, output logic r);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(a_w_ready || a_r_ready) && cyc < 20);
    w = a_w_ready;
    r = a_r_ready;
  endtask

  logic w_seen, r_seen;

  initial begin
    a_rst = 1'b1; a_w_valid = 1'b0; a_r_valid = 1'b0;
    a_w_addr = '0; a_w_data = '0; a_w_id = 4'h3; a_r_addr = '0; a_r_id = 4'h5;
    b_rst = 1'b1; b_w_valid = 1'b0; b_r_valid = 1'b0;
    b_w_addr = '0; b_w_data = '0; b_w_id = 4'h1; b_r_addr = '0; b_r_id = 4'h2;
    repeat (3) @(negedge clk);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", {a_w_ready, a_r_ready}, 2'b00);
    check("rst_resp", {a_w_resp, a_r_resp}, 4'h0);
    check("rst_rdata", a_r_data, 8'h00);
    check("rst_cnts", {a_wr_cnt, a_rd_cnt, a_err_cnt}, 48'h0);

    // 1. write then read, BASE 40, LATENCY 2
    xfer(0, 1, 8'h45, 8'hA5, 2'b00, 8'h00, "t1_w45");
    xfer(0, 0, 8'h45, 8'h00, 2'b00, 8'hA5, "t1_r45");
    check("t1_wr_cnt", a_wr_cnt, 16'd1);
    check("t1_rd_cnt", a_rd_cnt, 16'd1);

    // 2. out of range below and above, plus last owned word
    xfer(0, 1, 8'h3F, 8'hEE, 2'b10, 8'h00, "t2_w3f");
    xfer(0, 0, 8'h80, 8'h00, 2'b10, 8'h00, "t2_r80");
    xfer(0, 0, 8'h7F, 8'h00, 2'b00, 8'h00, "t2_r7f");
    check("t2_err_cnt", a_err_cnt, 16'd2);
    check("t2_wr_cnt", a_wr_cnt, 16'd1);
    check("t2_rd_cnt", a_rd_cnt, 16'd2);

    // 5. reset while in WAIT: dropped transaction, memory cleared
    @(negedge clk);
    a_w_valid = 1'b1; a_w_addr = 8'h45; a_w_data = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    a_rst = 1'b1;
    a_w_valid = 1'b0;
    @(negedge clk);
    a_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_no_pulse", {a_w_ready, a_r_ready, a_w_resp, a_r_resp}, 6'h0);
    end
    check("t5_cnts", {a_wr_cnt, a_rd_cnt, a_err_cnt}, 48'h0);
    xfer(0, 0, 8'h45, 8'h00, 2'b00, 8'h00, "t5_r45");
    $display("xfer t5_rst_in_wait: dut=0 W addr=45 dropped by reset");

    // 3. collisions after reset: write first, then the next collision favours read
    @(negedge clk);
    a_w_valid = 1'b1; a_w_addr = 8'h41; a_w_data = 8'h77;
    a_r_valid = 1'b1; a_r_addr = 8'h41;
    a_wait(w_seen, r_seen);
    check("t3_c1_first", {w_seen, r_seen}, 2'b10);
    check("t3_c1_wresp", a_w_resp, 2'b00);
    a_w_valid = 1'b0;
    $display("xfer t3_c1_w41: dut=0 W addr=41 data=77 resp=%0b", a_w_resp);
    a_wait(w_seen, r_seen);
    check("t3_c1_second", {w_seen, r_seen}, 2'b01);
    check("t3_c1_rdata", a_r_data, 8'h77);
    a_r_valid = 1'b0;
    $display("xfer t3_c1_r41: dut=0 R addr=41 rdata=%02h", a_r_data);
    @(negedge clk);
    a_w_valid = 1'b1; a_w_addr = 8'h42; a_w_data = 8'h88;
    a_r_valid = 1'b1; a_r_addr = 8'h41;
    a_wait(w_seen, r_seen);
    check("t3_c2_first", {w_seen, r_seen}, 2'b01);
    check("t3_c2_rdata", a_r_data, 8'h77);
    a_r_valid = 1'b0;
    $display("xfer t3_c2_r41: dut=0 R addr=41 rdata=%02h", a_r_data);
    a_wait(w_seen, r_seen);
    check("t3_c2_second", {w_seen, r_seen}, 2'b10);
    a_w_valid = 1'b0;
    $display("xfer t3_c2_w42: dut=0 W addr=42 data=88 resp=%0b", a_w_resp);
    xfer(0, 0, 8'h42, 8'h00, 2'b00, 8'h88, "t3_r42");

    // 4. LATENCY 0, BASE 00: back-to-back writes, read-back, boundaries
    xfer(1, 1, 8'h03, 8'h11, 2'b00, 8'h00, "t4_w03");
    xfer(1, 1, 8'h04, 8'h22, 2'b00, 8'h00, "t4_w04");
    xfer(1, 0, 8'h03, 8'h00, 2'b00, 8'h11, "t4_r03");
    xfer(1, 0, 8'h04, 8'h00, 2'b00, 8'h22, "t4_r04");
    xfer(1, 1, 8'h40, 8'h33, 2'b10, 8'h00, "t4_w40");
    xfer(1, 0, 8'h00, 8'h00, 2'b00, 8'h00, "t4_r00");
    check("t4_cnts", {b_wr_cnt, b_rd_cnt, b_err_cnt}, {16'd2, 16'd3, 16'd1});

    // 6. write counter saturation
    force dut_b.wr_cnt_reg = 16'hFFFE;
    @(negedge clk);
    release dut_b.wr_cnt_reg;
    @(negedge clk);
    check("t6_preset", b_wr_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      xfer(1, 1, 8'(8'h10 + i), 8'(8'hC0 + i), 2'b00, 8'h00, "t6_w");
      check("t6_wr_cnt", b_wr_cnt, 16'hFFFF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
